float_mult: RTL and testbench

Unsigned-mantissa, two's-complement-exponent floating-point multiplier for the FFT datapath. It multiplies two (mantissa, exponent) operands and leading-one normalizes the 20-bit product into a 15-bit mantissa and a 5-bit exponent. It is a fixed 2-stage pipeline on a single clock, and accepts one operand pair every cycle.

---
 rtl/float_pkg.sv | 24 ++
 rtl/float_norm.sv | 49 ++++
 rtl/float_mult.sv | 80 ++++++++
 tb/tb_float_mult.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/float_pkg.sv
// Shared constants and helpers for the float_mult FFT multiplier.
package float_pkg;

  localparam int MANT_W    = 10;
  localparam int EXP_W     = 5;
  localparam int RES_W     = 15;
  localparam int PROD_W    = 20;
  localparam int ESUM_W    = 7;
  localparam int NORM_BIAS = 5;
  localparam int EXP_MAX   = 15;
  localparam int EXP_MIN   = -16;

  // Leading-zero count from the MSB; an all-zero input returns 0 and is
  // handled separately by the zero-product path.
  function automatic logic [4:0] lzc20(input logic [PROD_W-1:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < PROD_W; i++) begin
      if (v[i]) n = 5'(PROD_W - 1 - i);
    end
    return n;
  endfunction

endpackage

// File: rtl/float_norm.sv
// Combinational leading-one normalizer with exponent saturation for the
// 20-bit mantissa product.
module float_norm
  import float_pkg::*;
(
  input  logic [PROD_W-1:0]        i_prod,
  input  logic signed [ESUM_W-1:0] i_exp_sum,
  output logic [RES_W-1:0]         o_mant,
  output logic [EXP_W-1:0]         o_exp,
  output logic                     o_ovf,
  output logic                     o_udf
);

  localparam logic signed [ESUM_W-1:0] BIAS_S = ESUM_W'(NORM_BIAS);
  localparam logic signed [ESUM_W-1:0] MAX_S  = ESUM_W'(EXP_MAX);
  localparam logic signed [ESUM_W-1:0] MIN_S  = ESUM_W'(EXP_MIN);

  logic [4:0]               w_lz;
  logic [RES_W-1:0]         w_mant_norm;
  logic signed [ESUM_W-1:0] w_exp_adj;

  assign w_lz = lzc20(i_prod);

  // Shift keeps the leading one at bit 19; the low bits are truncated.
  assign w_mant_norm = RES_W'((i_prod << w_lz) >> (PROD_W - RES_W));

  // Exact in 7 bits: range is -46..35.
  assign w_exp_adj = i_exp_sum + BIAS_S - $signed({2'b00, w_lz});

  always_comb begin
    o_mant = '0;
    o_exp  = '0;
    o_ovf  = 1'b0;
    o_udf  = 1'b0;
    if (i_prod != '0) begin
      if (w_exp_adj > MAX_S) begin
        o_mant = '1;
        o_exp  = EXP_W'(EXP_MAX);
        o_ovf  = 1'b1;
      end else if (w_exp_adj < MIN_S) begin
        o_udf  = 1'b1;
      end else begin
        o_mant = w_mant_norm;
        o_exp  = w_exp_adj[EXP_W-1:0];
      end
    end
  end

endmodule

// File: rtl/float_mult.sv
// Two-stage (mantissa, exponent) multiplier: stage 1 multiplies and adds
// exponents, stage 2 registers the normalized, saturated result.
module float_mult
  import float_pkg::*;
#(
  parameter int MANT_W = 10,
  parameter int EXP_W  = 5,
  parameter int RES_W  = 15
) (
  input  logic              clkExt,
  input  logic              rstN,
  input  logic              iValid,
  input  logic [MANT_W-1:0] iMant1,
  input  logic [EXP_W-1:0]  iExp1,
  input  logic [MANT_W-1:0] iMant2,
  input  logic [EXP_W-1:0]  iExp2,
  output logic [RES_W-1:0]  oMantR,
  output logic [EXP_W-1:0]  oExpR,
  output logic              oValid,
  output logic              oOvf,
  output logic              oUdf
);

  localparam int PW = 2 * MANT_W;
  localparam int SW = EXP_W + 2;

  logic [PW-1:0]        w_prod;
  logic signed [SW-1:0] w_exp_sum;

  logic [PW-1:0]        r_prod;
  logic signed [SW-1:0] r_exp_sum;
  logic                 r_vld1;

  logic [RES_W-1:0]     w_norm_mant;
  logic [EXP_W-1:0]     w_norm_exp;
  logic                 w_norm_ovf;
  logic                 w_norm_udf;

  assign w_prod    = {{MANT_W{1'b0}}, iMant1} * {{MANT_W{1'b0}}, iMant2};
  assign w_exp_sum = $signed({{2{iExp1[EXP_W-1]}}, iExp1})
                   + $signed({{2{iExp2[EXP_W-1]}}, iExp2});

  always_ff @(posedge clkExt or negedge rstN) begin
    if (!rstN) begin
      r_prod    <= '0;
      r_exp_sum <= '0;
      r_vld1    <= 1'b0;
    end else begin
      r_prod    <= w_prod;
      r_exp_sum <= w_exp_sum;
      r_vld1    <= iValid;
    end
  end

  float_norm u_norm (
    .i_prod    (r_prod),
    .i_exp_sum (r_exp_sum),
    .o_mant    (w_norm_mant),
    .o_exp     (w_norm_exp),
    .o_ovf     (w_norm_ovf),
    .o_udf     (w_norm_udf)
  );

  always_ff @(posedge clkExt or negedge rstN) begin
    if (!rstN) begin
      oMantR <= '0;
      oExpR  <= '0;
      oValid <= 1'b0;
      oOvf   <= 1'b0;
      oUdf   <= 1'b0;
    end else begin
      oMantR <= w_norm_mant;
      oExpR  <= w_norm_exp;
      oValid <= r_vld1;
      oOvf   <= w_norm_ovf;
      oUdf   <= w_norm_udf;
    end
  end

endmodule

// File: tb/tb_float_mult.sv
// Self-checking bench for float_mult: directed corner cases plus random
// streaming against an arithmetic reference model.
module tb_float_mult;

  logic        clkExt = 1'b0;
  logic        rstN;
  logic        iValid;
  logic [9:0]  iMant1, iMant2;
  logic [4:0]  iExp1, iExp2;
  logic [14:0] oMantR;
  logic [4:0]  oExpR;
  logic        oValid, oOvf, oUdf;

  typedef struct {
    logic [14:0] mant;
    logic [4:0]  expo;
    logic        v;
    logic        ovf;
    logic        udf;
  } res_t;

  res_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  float_mult dut (
    .clkExt (clkExt),
    .rstN   (rstN),
    .iValid (iValid),
    .iMant1 (iMant1),
    .iExp1  (iExp1),
    .iMant2 (iMant2),
    .iExp2  (iExp2),
    .oMantR (oMantR),
    .oExpR  (oExpR),
    .oValid (oValid),
    .oOvf   (oOvf),
    .oUdf   (oUdf)
  );

  always #5 clkExt = ~clkExt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, expv, $time);
    end
  endtask

  // Value-level model: P x 2^Es scaled until the leading one sits at bit 19.
  function automatic res_t ref_mult(input logic v, input logic [9:0] m1, input logic [4:0] e1,
                                    input logic [9:0] m2, input logic [4:0] e2);
    res_t   r;
    longint p;
    int     e;
    r.mant = '0; r.expo = '0; r.v = v; r.ovf = 1'b0; r.udf = 1'b0;
    p = longint'(m1) * longint'(m2);
    e = int'($signed(e1)) + int'($signed(e2));
    if (p == 0) return r;
    while (p < 64'h80000) begin
      p = p * 2;
      e = e - 1;
    end
    e = e + 5;
    if (e > 15) begin
      r.mant = 15'h7FFF;
      r.expo = 5'b01111;
      r.ovf  = 1'b1;
    end else if (e < -16) begin
      r.udf  = 1'b1;
    end else begin
      r.mant = 15'(p >> 5);
      r.expo = 5'(e);
    end
    return r;
  endfunction

  task automatic cyc(input logic v, input logic [9:0] m1, input logic [4:0] e1,
                     input logic [9:0] m2, input logic [4:0] e2);
    res_t x;
    @(negedge clkExt);
    if (q.size() == 2) begin
      x = q.pop_front();
      check("mant",  32'(oMantR), 32'(x.mant));
      check("exp",   32'(oExpR),  32'(x.expo));
      check("valid", 32'(oValid), 32'(x.v));
      check("ovf",   32'(oOvf),   32'(x.ovf));
      check("udf",   32'(oUdf),   32'(x.udf));
    end
    iValid = v; iMant1 = m1; iExp1 = e1; iMant2 = m2; iExp2 = e2;
    q.push_back(ref_mult(v, m1, e1, m2, e2));
  endtask

  // Asynchronous assertion between edges, release on a falling edge.
  task automatic do_reset();
    @(posedge clkExt);
    #2;
    rstN = 1'b0;
    iValid = 1'b0; iMant1 = '0; iExp1 = '0; iMant2 = '0; iExp2 = '0;
    #1;
    check("rst_mant",  32'(oMantR), 32'd0);
    check("rst_exp",   32'(oExpR),  32'd0);
    check("rst_valid", 32'(oValid), 32'd0);
    check("rst_ovf",   32'(oOvf),   32'd0);
    check("rst_udf",   32'(oUdf),   32'd0);
    @(negedge clkExt);
    rstN = 1'b1;
    q.delete();
    q.push_back(ref_mult(1'b0, 10'd0, 5'd0, 10'd0, 5'd0));
    q.push_back(ref_mult(1'b0, 10'd0, 5'd0, 10'd0, 5'd0));
  endtask

  function automatic logic [9:0] rnd_mant();
    int sel;
    sel = int'($urandom_range(0, 7));
    if (sel == 0) return 10'd0;
    if (sel == 1) return 10'd1023;
    if (sel == 2) return 10'd1;
    return 10'($urandom_range(0, 1023));
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstN = 1'b0;
    iValid = 1'b0; iMant1 = '0; iExp1 = '0; iMant2 = '0; iExp2 = '0;
    do_reset();

    for (int i = 0; i < 3; i++) cyc(1'b0, 10'd0, 5'd0, 10'd0, 5'd0);

    for (int i = 0; i < 6; i++)
      cyc(1'b1, 10'(476 + 3 * i), 5'b11101, 10'(272 + i), 5'b00011);

    cyc(1'b1, 10'd1023, 5'b01111, 10'd1023, 5'b01111);
    cyc(1'b1, 10'd1,    5'b10000, 10'd1,    5'b10000);
    cyc(1'b1, 10'd0,    5'b00111, 10'd555,  5'b00010);
    cyc(1'b1, 10'd731,  5'b11000, 10'd0,    5'b01111);
    cyc(1'b1, 10'd1023, 5'b00000, 10'd1023, 5'b00000);
    cyc(1'b0, 10'd1023, 5'b01010, 10'd1023, 5'b00110);
    cyc(1'b1, 10'd1023, 5'b01010, 10'd1023, 5'b00101);
    cyc(1'b1, 10'd1,    5'b10000, 10'd1,    5'b11110);

    for (int i = 0; i < 200; i++)
      cyc(1'($urandom_range(0, 1)), rnd_mant(), 5'($urandom), rnd_mant(), 5'($urandom));

    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b0, 10'd0, 5'd0, 10'd0, 5'd0);

    for (int i = 0; i < 200; i++)
      cyc(1'($urandom_range(0, 1)), rnd_mant(), 5'($urandom), rnd_mant(), 5'($urandom));

    cyc(1'b0, 10'd0, 5'd0, 10'd0, 5'd0);
    cyc(1'b0, 10'd0, 5'd0, 10'd0, 5'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
